icache_fetch_req_splitter: RTL

//  Parametrised fetch-group request splitter between fetch stage 1 and the icache/bootloader.

---
 rtl/icache_fetch_req_splitter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/icache_fetch_req_splitter.sv
// Fetch-group request splitter: queues fetch PCs and turns each into a registered group of
// double-word icache requests or a single bootloader request, held until accepted.
module icache_fetch_req_splitter #(
   parameter int FETCH_WORDS = 4,
   parameter int PEND_DEPTH = 2,
   parameter bit BOOT_EN = 1'b1,
   parameter int PADDR_WIDTH = 32,
   parameter int ID_W = 8,
   parameter bit MMU_DISABLED = 1'b0,
   parameter logic [PADDR_WIDTH-1:0] BOOT_BASE = PADDR_WIDTH'(32'h0001_0000),
   parameter logic [PADDR_WIDTH-1:0] BOOT_SIZE = PADDR_WIDTH'(32'h0001_0000),
   localparam int NUM_REQ = FETCH_WORDS / 2 + 1,
   localparam int OCC_W = $clog2(PEND_DEPTH + 1)
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           pc_in_valid,
   input  logic [31:0]                    pc_in_vaddr,
   input  logic [ID_W-1:0]                pc_in_id,
   output logic                           pc_in_ready,
   input  logic                           flush,
   input  logic [31:0]                    generation,
   input  logic [1:0]                     priv_rval,
   input  logic [31:0]                    satp,
   output logic [NUM_REQ-1:0]             icache_req_valid,
   output logic [NUM_REQ*ID_W-1:0]        icache_req_id,
   output logic [NUM_REQ*32-1:0]          icache_req_vaddr,
   output logic [NUM_REQ*PADDR_WIDTH-1:0] icache_req_paddr,
   output logic [NUM_REQ-1:0]             icache_req_paddr_valid,
   output logic [NUM_REQ*32-1:0]          icache_req_generation,
   output logic [NUM_REQ*32-1:0]          icache_req_satp,
   output logic [NUM_REQ*2-1:0]           icache_req_type,
   output logic [NUM_REQ*2-1:0]           icache_req_policy,
   input  logic                           icache_ready,
   output logic                           boot_req_valid,
   output logic [ID_W-1:0]                boot_req_id,
   output logic [PADDR_WIDTH-1:0]         boot_req_paddr,
   input  logic                           boot_ready,
   output logic [OCC_W-1:0]               occupancy
);

   localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
   localparam logic [1:0] M_MODE = 2'b11;
   localparam logic [1:0] REQ_TYPE_NONE = 2'd0;
   localparam logic [1:0] READ_DOUBLE_WORD = 2'd1;
   localparam logic [1:0] REQ_POLICY_NONE = 2'd0;
   localparam logic [1:0] READ_REQ_FROM_UPPER = 2'd1;

   typedef enum logic [1:0] {OUT_EMPTY, OUT_ICACHE, OUT_BOOT} out_state_e;

   typedef struct packed {
      logic [31:0]     vaddr;
      logic [ID_W-1:0] id;
      logic [31:0]     gen;
      logic [1:0]      priv;
      logic [31:0]     satp;
   } entry_t;

   entry_t              fifo_q [PEND_DEPTH];
   entry_t              stage_q, stage_d, in_entry, src_entry;
   out_state_e          state_q, state_d;
   logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [OCC_W-1:0]    count_q, count_d;
   logic                enq, accept, can_load, load_fifo, bypass, wr_fifo;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(PEND_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic is_boot(input entry_t e);
      logic [PADDR_WIDTH-1:0] pa;
      pa = PADDR_WIDTH'(e.vaddr);
      return BOOT_EN && (e.priv == M_MODE) && (pa >= BOOT_BASE) && ((pa - BOOT_BASE) < BOOT_SIZE);
   endfunction

   assign pc_in_ready = (count_q < OCC_W'(PEND_DEPTH));
   assign occupancy   = count_q;

   always_comb begin
      in_entry  = '{vaddr: pc_in_vaddr, id: pc_in_id, gen: generation, priv: priv_rval, satp: satp};
      enq       = pc_in_valid && pc_in_ready;
      accept    = ((state_q == OUT_ICACHE) && icache_ready) || ((state_q == OUT_BOOT) && boot_ready);
      can_load  = !flush && ((state_q == OUT_EMPTY) || accept);
      load_fifo = can_load && (count_q != '0);
      // An empty FIFO lets a new PC skip straight into the output stage for N+1 latency.
      bypass    = can_load && (count_q == '0) && enq;
      wr_fifo   = enq && !bypass;
      src_entry = load_fifo ? fifo_q[head_q] : in_entry;

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      state_d = state_q;
      stage_d = stage_q;

      if (flush) begin
         head_d  = tail_q;
         tail_d  = wr_fifo ? ptr_inc(tail_q) : tail_q;
         count_d = wr_fifo ? OCC_W'(1) : '0;
         state_d = OUT_EMPTY;
      end else begin
         if (wr_fifo) tail_d = ptr_inc(tail_q);
         if (load_fifo) head_d = ptr_inc(head_q);
         count_d = count_q + OCC_W'(wr_fifo) - OCC_W'(load_fifo);
         if (load_fifo || bypass) begin
            stage_d = src_entry;
            state_d = is_boot(src_entry) ? OUT_BOOT : OUT_ICACHE;
         end else if (accept) begin
            state_d = OUT_EMPTY;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= OUT_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         stage_q <= stage_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_fifo) fifo_q[tail_q] <= in_entry;
   end

   logic paddr_ok;
   assign paddr_ok = (stage_q.priv == M_MODE) || !stage_q.satp[31] || MMU_DISABLED;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
         logic        used, slot_valid;
         logic [31:0] dw_vaddr;
         // An odd-word start backs up to the enclosing double word and needs one extra slot.
         assign used       = (gi < FETCH_WORDS / 2) ? 1'b1 : stage_q.vaddr[2];
         assign slot_valid = (state_q == OUT_ICACHE) && used;
         assign dw_vaddr   = stage_q.vaddr + 32'(8 * gi) - {29'd0, stage_q.vaddr[2], 2'b00};

         assign icache_req_valid[gi]                             = slot_valid;
         assign icache_req_id[gi*ID_W +: ID_W]                   = slot_valid ? stage_q.id + ID_W'(gi) : '0;
         assign icache_req_vaddr[gi*32 +: 32]                    = slot_valid ? dw_vaddr : '0;
         assign icache_req_paddr[gi*PADDR_WIDTH +: PADDR_WIDTH]  = slot_valid ? PADDR_WIDTH'(dw_vaddr) : '0;
         assign icache_req_paddr_valid[gi]                       = slot_valid && paddr_ok;
         assign icache_req_generation[gi*32 +: 32]               = slot_valid ? stage_q.gen : '0;
         assign icache_req_satp[gi*32 +: 32]                     = slot_valid ? stage_q.satp : '0;
         assign icache_req_type[gi*2 +: 2]   = slot_valid ? READ_DOUBLE_WORD : REQ_TYPE_NONE;
         assign icache_req_policy[gi*2 +: 2] = slot_valid ? READ_REQ_FROM_UPPER : REQ_POLICY_NONE;
      end
   endgenerate

   assign boot_req_valid = (state_q == OUT_BOOT);
   assign boot_req_id    = (state_q == OUT_BOOT) ? stage_q.id : '0;
   assign boot_req_paddr = (state_q == OUT_BOOT) ? PADDR_WIDTH'(stage_q.vaddr) : '0;

endmodule
